// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Round-robin arbiter that merges the result streams of several functional-unit
// pipes onto a single register-file write port, and records which pipe
// completed into a one-entry completion register for a downstream consumer.
//
// Parameters
//   p_num_pipes  number of result pipes (2..8)
//   p_num_regs   architectural registers; address width is clog2(p_num_regs)
//   p_data_bits  result data width
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous, active-high reset
//   pipe_val        per-pipe "result present"
//   pipe_rdy        per-pipe "result accepted this cycle" (one-hot or zero)
//   pipe_waddr      per-pipe destination register, pipe i at [i*AW +: AW]
//   pipe_wdata      per-pipe result value, pipe i at [i*DW +: DW]
//   pipe_wen        per-pipe "result writes a register"
//   waddr/wdata/wen register-file write port, driven in the grant cycle
//   complete_val    completion record valid (registered)
//   complete_rdy    downstream consumes the completion record
//   complete_pipe   index of the pipe the record came from
//   complete_waddr  destination register of the completed result
//   complete_wen    write flag of the completed result

module writeback_arbiter #(
    parameter int p_num_pipes = 4,
    parameter int p_num_regs  = 32,
    parameter int p_data_bits = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [p_num_pipes-1:0]                        pipe_val,
    output logic [p_num_pipes-1:0]                        pipe_rdy,
    input  logic [p_num_pipes*$clog2(p_num_regs)-1:0]     pipe_waddr,
    input  logic [p_num_pipes*p_data_bits-1:0]            pipe_wdata,
    input  logic [p_num_pipes-1:0]                        pipe_wen,
    output logic [$clog2(p_num_regs)-1:0]                 waddr,
    output logic [p_data_bits-1:0]                        wdata,
    output logic                                          wen,
    output logic                                          complete_val,
    input  logic                                          complete_rdy,
    output logic [$clog2(p_num_pipes)-1:0]                complete_pipe,
    output logic [$clog2(p_num_regs)-1:0]                 complete_waddr,
    output logic                                          complete_wen
);

    localparam int AW = $clog2(p_num_regs);
    localparam int DW = p_data_bits;
    localparam int PW = $clog2(p_num_pipes);

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;
    logic [PW:0]   cand;
    logic          any_val;
    logic          can_accept;
    logic          grant;

    // The completion slot is free if empty, or if its record leaves this
    // cycle; the latter lets the slot drain and refill on the same edge.
    assign can_accept = !complete_val || complete_rdy;
    assign grant      = !rst && can_accept && any_val;

    // Search ptr, ptr+1, ... with wrap; the first valid pipe wins. cand is one
    // bit wider than ptr so ptr+k never overflows before the wrap correction.
    always_comb begin
        any_val   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < p_num_pipes; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(p_num_pipes)) begin
                cand = cand - (PW+1)'(p_num_pipes);
            end
            if (!any_val && pipe_val[cand[PW-1:0]]) begin
                any_val   = 1'b1;
                grant_idx = cand[PW-1:0];
            end
        end
    end

    // Grant side: ready is asserted only on the winner, and the write port
    // forwards the winner's result in the same cycle. Zeroed when idle so the
    // register file never sees stale addresses or data.
    always_comb begin
        pipe_rdy = '0;
        wen      = 1'b0;
        waddr    = '0;
        wdata    = '0;
        if (grant) begin
            pipe_rdy[grant_idx] = 1'b1;
            wen                 = pipe_wen[grant_idx];
            waddr               = pipe_waddr[grant_idx*AW +: AW];
            wdata               = pipe_wdata[grant_idx*DW +: DW];
        end
    end

    // Pointer moves to one past the winner, so the winner has lowest priority
    // next time; a grant overwrites the completion slot (the old record, if
    // any, is being consumed this cycle), otherwise a consumed record clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= '0;
            complete_val   <= 1'b0;
            complete_pipe  <= '0;
            complete_waddr <= '0;
            complete_wen   <= 1'b0;
        end else if (grant) begin
            ptr            <= (grant_idx == PW'(p_num_pipes-1)) ? '0 : grant_idx + 1'b1;
            complete_val   <= 1'b1;
            complete_pipe  <= grant_idx;
            complete_waddr <= pipe_waddr[grant_idx*AW +: AW];
            complete_wen   <= pipe_wen[grant_idx];
        end else if (complete_rdy) begin
            complete_val   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//
// Directed scoreboard bench for writeback_arbiter (4 pipes, 32 regs, 32-bit
// data). Each stimulus cycle pushes the hand-computed write-port response and
// any expected completion record; a monitor on the falling edge pops and
// compares.

module tb_writeback_arbiter;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N-1:0]    pipe_val;
    logic [N-1:0]    pipe_rdy;
    logic [N*AW-1:0] pipe_waddr;
    logic [N*DW-1:0] pipe_wdata;
    logic [N-1:0]    pipe_wen;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic            wen;
    logic            complete_val;
    logic            complete_rdy;
    logic [1:0]      complete_pipe;
    logic [AW-1:0]   complete_waddr;
    logic            complete_wen;

    typedef struct {
        logic [N-1:0]  rdy;
        logic          wen;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          cval;
    } wr_exp_t;

    typedef struct {
        logic [1:0]    pipe;
        logic [AW-1:0] waddr;
        logic          wen;
    } cmp_exp_t;

    wr_exp_t  wq[$];
    cmp_exp_t cq[$];

    int checks = 0;
    int passes = 0;
    int tag    = 0;

    writeback_arbiter #(
        .p_num_pipes(N),
        .p_num_regs (32),
        .p_data_bits(DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_val      (pipe_val),
        .pipe_rdy      (pipe_rdy),
        .pipe_waddr    (pipe_waddr),
        .pipe_wdata    (pipe_wdata),
        .pipe_wen      (pipe_wen),
        .waddr         (waddr),
        .wdata         (wdata),
        .wen           (wen),
        .complete_val  (complete_val),
        .complete_rdy  (complete_rdy),
        .complete_pipe (complete_pipe),
        .complete_waddr(complete_waddr),
        .complete_wen  (complete_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. exp_g is the hand-computed granted pipe (-1 for
    // none), exp_cval the complete_val expected during this cycle. ov selects
    // a pipe whose result is forced to waddr=5 / wdata=0xDEADBEEF.
    task automatic applyStimulus(input logic r, input logic [N-1:0] val,
                                 input logic [N-1:0] wmask, input logic crdy,
                                 input int exp_g, input logic exp_cval,
                                 input int ov);
        wr_exp_t  e;
        cmp_exp_t c;
        @(posedge clk);
        #1;
        tag++;
        rst          = r;
        pipe_val     = val;
        pipe_wen     = wmask;
        complete_rdy = crdy;
        for (int i = 0; i < N; i++) begin
            if (i == ov) begin
                pipe_waddr[i*AW +: AW] = 5'd5;
                pipe_wdata[i*DW +: DW] = 32'hDEADBEEF;
            end else begin
                pipe_waddr[i*AW +: AW] = 5'(tag*3 + i);
                pipe_wdata[i*DW +: DW] = 32'hA000_0000 | 32'(tag << 8) | 32'(i);
            end
        end
        // A reset with a pending record discards it, so drop its expectation.
        if (r && exp_cval && cq.size() > 0) begin
            void'(cq.pop_back());
        end
        e.cval = exp_cval;
        if (exp_g >= 0) begin
            e.rdy   = 4'(1 << exp_g);
            e.wen   = wmask[exp_g];
            e.waddr = (exp_g == ov) ? 5'd5 : 5'(tag*3 + exp_g);
            e.wdata = (exp_g == ov) ? 32'hDEADBEEF : (32'hA000_0000 | 32'(tag << 8) | 32'(exp_g));
            c.pipe  = 2'(exp_g);
            c.waddr = e.waddr;
            c.wen   = e.wen;
            cq.push_back(c);
        end else begin
            e.rdy   = '0;
            e.wen   = 1'b0;
            e.waddr = '0;
            e.wdata = '0;
        end
        wq.push_back(e);
    endtask

    // Monitor: write-port response every stimulus cycle; completion record on
    // handshake (pop) or under backpressure (must match the head, unchanged).
    always @(negedge clk) begin
        wr_exp_t  e;
        cmp_exp_t c;
        if (wq.size() > 0) begin
            e = wq.pop_front();
            checkOutput("pipe_rdy", 32'(pipe_rdy), 32'(e.rdy));
            checkOutput("wen", 32'(wen), 32'(e.wen));
            checkOutput("waddr", 32'(waddr), 32'(e.waddr));
            checkOutput("wdata", wdata, e.wdata);
            checkOutput("complete_val", 32'(complete_val), 32'(e.cval));
        end
        if (!rst && complete_val === 1'b1) begin
            if (cq.size() == 0) begin
                checkOutput("unexpected_completion", 32'(complete_val), 32'd0);
            end else begin
                c = complete_rdy ? cq.pop_front() : cq[0];
                checkOutput("complete_pipe", 32'(complete_pipe), 32'(c.pipe));
                checkOutput("complete_waddr", 32'(complete_waddr), 32'(c.waddr));
                checkOutput("complete_wen", 32'(complete_wen), 32'(c.wen));
            end
        end
    end

    initial begin
        rst          = 1'b1;
        pipe_val     = '0;
        pipe_wen     = '0;
        pipe_waddr   = '0;
        pipe_wdata   = '0;
        complete_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held with all pipes requesting: nothing may be granted.
        applyStimulus(1, 4'b1111, 4'b1111, 1, -1, 0, -1);

        // All pipes valid, sink always ready: 0,1,2,3 back to back.
        applyStimulus(0, 4'b1111, 4'b1111, 1, 0, 0, -1);
        applyStimulus(0, 4'b1111, 4'b1111, 1, 1, 1, -1);
        applyStimulus(0, 4'b1111, 4'b1111, 1, 2, 1, -1);
        applyStimulus(0, 4'b1111, 4'b1111, 1, 3, 1, -1);
        applyStimulus(0, 4'b0000, 4'b0000, 1, -1, 1, -1);

        // Move ptr to 2, then wrap-around search picks 0 then 1.
        applyStimulus(0, 4'b0010, 4'b1111, 1, 1, 0, -1);
        applyStimulus(0, 4'b0011, 4'b1111, 1, 0, 1, -1);
        applyStimulus(0, 4'b0011, 4'b1111, 1, 1, 1, -1);
        applyStimulus(0, 4'b0000, 4'b0000, 1, -1, 1, -1);

        // Pipe 1 writes x5 <= DEADBEEF, then 3 cycles of backpressure.
        applyStimulus(0, 4'b0010, 4'b1111, 1, 1, 0, 1);
        applyStimulus(0, 4'b1111, 4'b1111, 0, -1, 1, -1);
        applyStimulus(0, 4'b1111, 4'b1111, 0, -1, 1, -1);
        applyStimulus(0, 4'b1111, 4'b1111, 0, -1, 1, -1);
        applyStimulus(0, 4'b1111, 4'b1111, 1, 2, 1, -1);

        // Granted result that does not write a register.
        applyStimulus(0, 4'b1000, 4'b0000, 1, 3, 1, -1);
        applyStimulus(0, 4'b0000, 4'b0000, 1, -1, 1, -1);

        // Reset while a record is pending; pipe 2 wins right after reset.
        applyStimulus(0, 4'b0001, 4'b1111, 0, 0, 0, -1);
        applyStimulus(1, 4'b0100, 4'b1111, 1, -1, 1, -1);
        applyStimulus(0, 4'b0100, 4'b1111, 1, 2, 0, -1);
        applyStimulus(0, 4'b0000, 4'b0000, 1, -1, 1, -1);
        applyStimulus(0, 4'b0000, 4'b0000, 1, -1, 0, -1);

        @(posedge clk);
        @(negedge clk);
        checkOutput("completions_outstanding", 32'(cq.size()), 32'd0);
        checkOutput("writes_outstanding", 32'(wq.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
